// File: rtl/btb_update_if.sv
// btb_update_if: resolve, redirect, BTB write-port and statistics signals of the BTB update unit
interface btb_update_if #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 20
);
  logic                  res_valid;
  logic [31:0]           res_pc;
  logic                  res_taken;
  logic [31:0]           res_target;
  logic                  res_pred_hit;
  logic [31:0]           res_pred_target;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic                  upd_en;
  logic [INDEX_BITS-1:0] upd_index;
  logic [TAG_BITS-1:0]   upd_tag;
  logic [31:0]           upd_target;
  logic                  upd_ready;
  logic                  q_full;
  logic [31:0]           stat_branches;
  logic [31:0]           stat_mispredicts;
  logic [31:0]           stat_dropped;
  modport master (
    output res_valid, res_pc, res_taken, res_target, res_pred_hit, res_pred_target, upd_ready,
    input  redirect_valid, redirect_pc, upd_en, upd_index, upd_tag, upd_target, q_full,
           stat_branches, stat_mispredicts, stat_dropped
  );
  modport slave (
    input  res_valid, res_pc, res_taken, res_target, res_pred_hit, res_pred_target, upd_ready,
    output redirect_valid, redirect_pc, upd_en, upd_index, upd_tag, upd_target, q_full,
           stat_branches, stat_mispredicts, stat_dropped
  );
endinterface

// File: rtl/btb_update_unit.sv
// btb_update_unit: resolves branches, issues redirects, queues coalesced BTB updates
module btb_update_unit #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 20,
  parameter int DEPTH      = 4
) (
  input logic         clk,
  input logic         reset,
  btb_update_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  logic [INDEX_BITS-1:0] r_idx [DEPTH];
  logic [TAG_BITS-1:0]   r_tag [DEPTH];
  logic [31:0]           r_tgt [DEPTH];
  logic [PW-1:0]         r_head, r_tail;
  logic [PW:0]           r_count;
  logic                  r_redir_v;
  logic [31:0]           r_redir_pc, r_br, r_mp, r_dr;
  logic [31:0]           w_seq, w_pred, w_act;
  logic                  w_mis, w_wr, w_full, w_pop, w_any, w_hit, w_push, w_drop;
  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic [DEPTH-1:0]      w_match;
  logic [PW-1:0]         w_slot;
  assign w_seq   = bus.res_pc + 32'd4;
  assign w_pred  = bus.res_pred_hit ? bus.res_pred_target : w_seq;
  assign w_act   = bus.res_taken ? bus.res_target : w_seq;
  assign w_mis   = bus.res_valid && (w_pred != w_act);
  assign w_wr    = bus.res_valid && bus.res_taken && (!bus.res_pred_hit || bus.res_pred_target != bus.res_target);
  assign w_index = bus.res_pc[INDEX_BITS+1:2];
  assign w_tag   = bus.res_pc[31:32-TAG_BITS];
  assign w_full  = r_count == (PW+1)'(DEPTH);
  assign w_pop   = (r_count != '0) && bus.upd_ready;
  // A slot is live when its distance from the head is below the count; the head leaving this cycle cannot absorb a write
  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    logic [PW-1:0] w_off;
    assign w_off      = PW'(g) - r_head;
    assign w_match[g] = ({1'b0, w_off} < r_count) && (r_idx[g] == w_index) && !(w_pop && PW'(g) == r_head);
  end
  assign w_any  = |w_match;
  assign w_hit  = w_wr && w_any;
  assign w_push = w_wr && !w_any && (!w_full || w_pop);
  assign w_drop = w_wr && !w_any && w_full && !w_pop;
  // Coalescing keeps indices unique in the queue, so at most one slot matches
  always_comb begin
    w_slot = '0;
    for (int i = 0; i < DEPTH; i++) w_slot = w_match[i] ? PW'(i) : w_slot;
  end
  // Queue storage and pointers: pop at head, append at tail, overwrite a matching slot in place
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_idx[i] <= '0;
        r_tag[i] <= '0;
        r_tgt[i] <= '0;
      end
    end else begin
      if (w_pop) r_head <= r_head + PW'(1);
      if (w_push) begin
        r_idx[r_tail] <= w_index;
        r_tag[r_tail] <= w_tag;
        r_tgt[r_tail] <= bus.res_target;
        r_tail        <= r_tail + PW'(1);
      end
      if (w_hit) begin
        r_tag[w_slot] <= w_tag;
        r_tgt[w_slot] <= bus.res_target;
      end
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end
  // One-cycle redirect pulse; the target is held between mispredicts
  always_ff @(posedge clk) begin
    if (reset) begin
      r_redir_v  <= 1'b0;
      r_redir_pc <= '0;
    end else begin
      r_redir_v  <= w_mis;
      r_redir_pc <= w_mis ? w_act : r_redir_pc;
    end
  end
  // Free-running statistics, wrapping modulo 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      r_br <= '0;
      r_mp <= '0;
      r_dr <= '0;
    end else begin
      r_br <= r_br + 32'(bus.res_valid);
      r_mp <= r_mp + 32'(w_mis);
      r_dr <= r_dr + 32'(w_drop);
    end
  end
  assign bus.redirect_valid   = r_redir_v;
  assign bus.redirect_pc      = r_redir_pc;
  assign bus.upd_en           = r_count != '0;
  assign bus.upd_index        = r_idx[r_head];
  assign bus.upd_tag          = r_tag[r_head];
  assign bus.upd_target       = r_tgt[r_head];
  assign bus.q_full           = w_full;
  assign bus.stat_branches    = r_br;
  assign bus.stat_mispredicts = r_mp;
  assign bus.stat_dropped     = r_dr;
endmodule

// File: tb/tb_btb_update_unit.sv
// tb_btb_update_unit: directed and random checks of btb_update_unit against a queue-based model
module tb_btb_update_unit;
  localparam int DEPTH = 4;
  typedef struct {
    logic [5:0]  idx;
    logic [19:0] tag;
    logic [31:0] tgt;
  } ent_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  ent_t q[$];
  logic m_rv = 1'b0;
  logic [31:0] m_rpc = '0, m_br = '0, m_mp = '0, m_dr = '0;
  btb_update_if #(.INDEX_BITS(6), .TAG_BITS(20)) bus ();
  btb_update_unit #(.INDEX_BITS(6), .TAG_BITS(20), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    check("redirect_valid", 32'(bus.redirect_valid), 32'(m_rv));
    check("redirect_pc", bus.redirect_pc, m_rpc);
    check("upd_en", 32'(bus.upd_en), 32'(q.size() != 0));
    check("q_full", 32'(bus.q_full), 32'(q.size() == DEPTH));
    check("stat_branches", bus.stat_branches, m_br);
    check("stat_mispredicts", bus.stat_mispredicts, m_mp);
    check("stat_dropped", bus.stat_dropped, m_dr);
    if (q.size() != 0) begin
      check("upd_index", 32'(bus.upd_index), 32'(q[0].idx));
      check("upd_tag", 32'(bus.upd_tag), 32'(q[0].tag));
      check("upd_target", bus.upd_target, q[0].tgt);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic ph, input logic [31:0] pt, input logic rdy);
    bus.res_valid = v;
    bus.res_pc = pc;
    bus.res_taken = tk;
    bus.res_target = tgt;
    bus.res_pred_hit = ph;
    bus.res_pred_target = pt;
    bus.upd_ready = rdy;
  endtask
  task automatic cyc(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic ph, input logic [31:0] pt, input logic rdy);
    logic [31:0] pn, an;
    logic wr, found;
    @(negedge clk);
    drive(v, pc, tk, tgt, ph, pt, rdy);
    pn = ph ? pt : pc + 32'd4;
    an = tk ? tgt : pc + 32'd4;
    m_rv = v && (pn != an);
    if (m_rv) m_rpc = an;
    if (v) m_br++;
    if (m_rv) m_mp++;
    wr = v && tk && (!ph || pt != tgt);
    if (q.size() != 0 && rdy) void'(q.pop_front());
    if (wr) begin
      found = 1'b0;
      foreach (q[k]) if (q[k].idx == pc[7:2]) begin
        q[k].tag = pc[31:12];
        q[k].tgt = tgt;
        found = 1'b1;
      end
      if (!found) begin
        if (q.size() < DEPTH) q.push_back('{pc[7:2], pc[31:12], tgt});
        else m_dr++;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic rst();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 32'h3000, 1'b1, 32'h4000, 1'b0, 32'h0, 1'b1);
    q.delete();
    m_rv = 1'b0;
    m_rpc = '0;
    m_br = '0;
    m_mp = '0;
    m_dr = '0;
    @(posedge clk);
    #1;
    check_all();
    check("rst_upd_index", 32'(bus.upd_index), 32'h0);
    check("rst_upd_tag", 32'(bus.upd_tag), 32'h0);
    check("rst_upd_target", bus.upd_target, 32'h0);
    reset = 1'b0;
  endtask
  initial begin
    logic [31:0] pc, tgt;
    logic tk, ph;
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    rst();
    cyc(1, 32'h1040, 1, 32'h2000, 0, 32'h0, 1);
    check("cold_redir_v", 32'(bus.redirect_valid), 32'h1);
    check("cold_redir_pc", bus.redirect_pc, 32'h2000);
    check("cold_upd_en", 32'(bus.upd_en), 32'h1);
    check("cold_index", 32'(bus.upd_index), 32'h10);
    check("cold_tag", 32'(bus.upd_tag), 32'h1);
    check("cold_target", bus.upd_target, 32'h2000);
    cyc(0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    check("cold_drained", 32'(bus.upd_en), 32'h0);
    rst();
    cyc(1, 32'h100, 1, 32'h200, 1, 32'h200, 1);
    check("correct_branches", bus.stat_branches, 32'h1);
    check("correct_mispred", bus.stat_mispredicts, 32'h0);
    cyc(1, 32'h100, 0, 32'h0, 1, 32'h200, 1);
    check("stale_redir_pc", bus.redirect_pc, 32'h104);
    check("stale_mispred", bus.stat_mispredicts, 32'h1);
    rst();
    cyc(1, 32'h40, 1, 32'h500, 0, 32'h0, 0);
    cyc(1, 32'h40, 1, 32'h600, 0, 32'h0, 0);
    check("coal_target", bus.upd_target, 32'h600);
    cyc(0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    check("coal_single", 32'(bus.upd_en), 32'h0);
    rst();
    for (int k = 0; k < 5; k++) cyc(1, 32'h100 + 32'(4 * k), 1, 32'h8000 + 32'(k), 0, 32'h0, 0);
    check("ovf_full", 32'(bus.q_full), 32'h1);
    check("ovf_dropped", bus.stat_dropped, 32'h1);
    cyc(1, 32'h200, 1, 32'h9000, 0, 32'h0, 1);
    check("popfull_dropped", bus.stat_dropped, 32'h1);
    check("popfull_full", 32'(bus.q_full), 32'h1);
    check("popfull_head", bus.upd_target, 32'h8001);
    cyc(0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    cyc(0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    rst();
    check("middrain_en", 32'(bus.upd_en), 32'h0);
    check("middrain_br", bus.stat_branches, 32'h0);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) rst();
      else begin
        pc = (32'($urandom_range(0, 1)) << 12) | (32'($urandom_range(0, 7)) << 2);
        tgt = 32'($urandom_range(0, 3)) << 4;
        tk = 1'($urandom_range(0, 1));
        ph = 1'($urandom_range(0, 1));
        cyc(1'($urandom_range(0, 4) != 0), pc, tk, tgt, ph,
            $urandom_range(0, 1) ? tgt : 32'($urandom_range(0, 3)) << 4, $urandom_range(0, 9) < 3);
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/btb_update_unit.md
# btb_update_unit

Branch-resolution side of the branch target buffer. It takes each resolved control-transfer instruction from EX, compares the actual outcome with the fetch-time BTB prediction, and issues a one-cycle registered redirect on a mispredict. Required BTB writes are queued in a small coalescing FIFO and drained one per cycle into the BTB write port (`update_en` / `update_index` / `update_tag` / `update_target`). It also keeps branch, mispredict and drop statistics.

## Interface
- `INDEX_BITS`, 6: BTB index width. Index is `pc[INDEX_BITS+1:2]`.
- `TAG_BITS`, 20: BTB tag width. Tag is `pc[31:32-TAG_BITS]`. Legal only if `INDEX_BITS+2 <= 32-TAG_BITS`.
- `DEPTH`, 4: update FIFO entries. Power of two, at least 2.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `res_valid` in 1: a resolved control-transfer instruction is presented this cycle.
- `res_pc` in 32: PC of the resolved instruction.
- `res_taken` in 1: actual branch direction.
- `res_target` in 32: actual taken target.
- `res_pred_hit` in 1: BTB hit recorded at fetch.
- `res_pred_target` in 32: BTB target recorded at fetch.
- `redirect_valid` out 1: registered one-cycle pulse requesting a fetch redirect.
- `redirect_pc` out 32: correct next PC.
- `upd_en` out 1: FIFO head is valid.
- `upd_index` out `INDEX_BITS`: head index.
- `upd_tag` out `TAG_BITS`: head tag.
- `upd_target` out 32: head target.
- `upd_ready` in 1: BTB write port accepts this cycle.
- `q_full` out 1: FIFO holds `DEPTH` entries.
- `stat_branches` out 32: count of resolved instructions.
- `stat_mispredicts` out 32: count of mispredicts.
- `stat_dropped` out 32: count of dropped updates.

## Operation
- **Predicted next PC:** `res_pred_hit ? res_pred_target : res_pc+4`.
- **Actual next PC:** `res_taken ? res_target : res_pc+4`. All PC adds are 32-bit modulo.
- **Mispredict:** `res_valid` and predicted next PC ≠ actual next PC.
- **Redirect:** on a mispredict, `redirect_valid` is 1 in the following cycle and `redirect_pc` = actual next PC. Otherwise `redirect_valid` is 0 and `redirect_pc` holds its last value.
- **Write required:** `res_valid && res_taken && (!res_pred_hit || res_pred_target != res_target)`. A not-taken instruction never writes; stale BTB entries are left in place because the BTB has no invalidate.
- **FIFO entry:** {index, tag, target} derived from `res_pc` and `res_target`.
- **Enqueue with coalescing:**
  - If a valid queued entry has the same index, overwrite its tag and target in place. Queue position and count are unchanged.
  - The head entry being popped in the same cycle is excluded from the match.
  - Otherwise append at the tail.
- **Dequeue:** `upd_en` = FIFO not empty, driven directly from head storage. The head pops when `upd_en && upd_ready`. `upd_*` are stable while `upd_ready` is 0.
- **Full:** an append is allowed when not full, or when a pop happens in the same cycle. A required write that can neither coalesce nor append is discarded and `stat_dropped` increments. The redirect still occurs.
- **Counters:** `stat_branches` increments on every `res_valid`. `stat_mispredicts` increments on every mispredict. All counters wrap modulo 2^32.
- **Statelessness:** there is no backpressure to the pipeline; `res_valid` is accepted every cycle.

## Timing
- **Reset:** all outputs 0 (`redirect_valid`, `redirect_pc`, `upd_*`, `q_full`, all stats). FIFO empty, pointers 0.
- **Reset mid-operation:** discards all queued entries and clears the stats. A pending redirect is suppressed.
- **Redirect latency:** exactly 1 cycle after `res_valid`.
- **Update latency:** an entry appended at edge N appears on `upd_en`/`upd_*` after edge N, i.e. in cycle N+1 if the FIFO was empty.
- **Throughput:** one pop per cycle while `upd_ready` is high.
- **Simultaneous enqueue and pop at full:** count stays `DEPTH` and nothing is dropped.
- **Pointer wrap:** pointers wrap modulo `DEPTH`. Full and empty are distinguished by an extra wrap bit or a count register.
- **`q_full`:** combinational from the count, i.e. registered state.

## Test plan
- **Cold taken miss:** reset, then `res_valid` with pc=0x00001040, taken=1, target=0x00002000, pred_hit=0, `upd_ready`=1 → next cycle `redirect_valid`=1, `redirect_pc`=0x00002000, `upd_en`=1, `upd_index`=0x10, `upd_tag`=0x00001, `upd_target`=0x00002000. The following cycle `upd_en`=0.
- **Correct prediction:** pc=0x100, taken=1, target=0x200, pred_hit=1, pred_target=0x200 → no redirect, no enqueue. `stat_branches`=1, `stat_mispredicts`=0.
- **Not-taken with stale hit:** pc=0x100, taken=0, pred_hit=1, pred_target=0x200 → `redirect_pc`=0x104, no enqueue, `stat_mispredicts`=1.
- **Coalescing:** hold `upd_ready`=0 and resolve pc=0x40→0x500, then pc=0x40→0x600 (same index) → count=1. Head target=0x600.
- **Overflow:** `upd_ready`=0 and five distinct-index taken misses with `DEPTH`=4 → `q_full`=1 after the 4th, `stat_dropped`=1. With `upd_ready`=1, the four entries drain in order on 4 consecutive cycles.
- **Pop and append at full:** at full with `upd_ready`=1, a new miss is appended in the same cycle. `stat_dropped` is unchanged and the count stays 4. Asserting `reset` mid-drain gives `upd_en`=0 and all stats 0 the next cycle.
